// File: rtl/reaction_game_ctrl_if.sv
// Player-facing signal bundle of the reaction game: raw button in, digits/LEDs/state out.
// The master side is the game controller; the slave side is the board/display.
interface reaction_game_ctrl_if;
  logic       btn;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       go_led;
  logic       early;
  logic [1:0] state_o;

  modport master (
    input  btn,
    output tens,
    output ones,
    output go_led,
    output early,
    output state_o
  );

  modport slave (
    output btn,
    input  tens,
    input  ones,
    input  go_led,
    input  early,
    input  state_o
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: button sync, random READY wait from an LFSR,
// and a two-digit BCD response timer driving the seven-segment decoder.
module reaction_game_ctrl #(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned MIN_WAIT_TICKS = 100,
  parameter int unsigned WAIT_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reaction_game_ctrl_if.master io
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned WC_W  = WAIT_BITS + 1 + $clog2(MIN_WAIT_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [WC_W-1:0]  WAIT_MIN = WC_W'(MIN_WAIT_TICKS);
  localparam logic [WC_W-1:0]  WAIT_ONE = WC_W'(1);
  localparam logic [3:0]       BLANK    = 4'hA;
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    START  = 2'd0,
    READY  = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [3:0]       tens_q, tens_n;
  logic [3:0]       ones_q, ones_n;
  logic             go_q, go_n;
  logic             early_q, early_n;
  logic [WC_W-1:0]  wait_cnt, wait_n;
  logic [PRE_W-1:0] presc;
  logic [15:0]      lfsr;
  logic             btn_s1, btn_s2, btn_prev;
  logic             press;
  logic             tick;
  logic             lfsr_fb;

  // Two-stage synchronizer plus edge detector on the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= io.btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  assign tick = (presc == PRE_LAST);

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= START;
      tens_q   <= BLANK;
      ones_q   <= BLANK;
      go_q     <= 1'b0;
      early_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      tens_q   <= tens_n;
      ones_q   <= ones_n;
      go_q     <= go_n;
      early_q  <= early_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n = state;
    tens_n  = tens_q;
    ones_n  = ones_q;
    early_n = early_q;
    wait_n  = wait_cnt;

    case (state)
      START: begin
        tens_n  = BLANK;
        ones_n  = BLANK;
        early_n = 1'b0;
        if (press) begin
          state_n = READY;
          wait_n  = WAIT_MIN + WC_W'(lfsr[WAIT_BITS-1:0]);
        end
      end

      READY: begin
        // Press is tested first so it beats an expiring tick in the same cycle
        if (press) begin
          state_n = FINISH;
          early_n = 1'b1;
          tens_n  = 4'd9;
          ones_n  = 4'd9;
        end else if (tick) begin
          if (wait_cnt <= WAIT_ONE) begin
            state_n = PLAY;
            tens_n  = 4'd0;
            ones_n  = 4'd0;
            wait_n  = '0;
          end else begin
            wait_n = wait_cnt - WAIT_ONE;
          end
        end
      end

      PLAY: begin
        if (press) begin
          state_n = FINISH;
        end else if (tick) begin
          if (ones_q >= 4'd9) begin
            if (tens_q >= 4'd9) begin
              state_n = FINISH;
              early_n = 1'b0;
            end else begin
              ones_n = 4'd0;
              tens_n = tens_q + 4'd1;
            end
          end else begin
            ones_n = ones_q + 4'd1;
          end
        end
      end

      FINISH: begin
        if (press) begin
          state_n = START;
          tens_n  = BLANK;
          ones_n  = BLANK;
          early_n = 1'b0;
        end
      end

      default: begin
        state_n = START;
        tens_n  = BLANK;
        ones_n  = BLANK;
        early_n = 1'b0;
      end
    endcase

    go_n = (state_n == PLAY);
  end

  assign io.tens    = tens_q;
  assign io.ones    = ones_q;
  assign io.go_led  = go_q;
  assign io.early   = early_q;
  assign io.state_o = state;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: directed rounds plus random rounds,
// compared every cycle against a timeline model derived from the game rules.
module tb_reaction_game_ctrl;

  localparam int TD   = 4;
  localparam int MINW = 2;
  localparam int WB   = 2;
  localparam int BIG  = 1 << 30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reaction_game_ctrl_if bus();

  reaction_game_ctrl #(
    .TICK_DIV(TD),
    .MIN_WAIT_TICKS(MINW),
    .WAIT_BITS(WB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  // Cycles elapsed since reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  // Round timeline: start press cycle, last READY cycle, first PLAY cycle,
  // finishing press cycle, return-to-START press cycle
  int rp, rtw, re, rq, rret;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int ticks_upto(input int x);
    return (x < 0) ? 0 : (x + 1) / TD;
  endfunction

  function automatic int ticks_in(input int a, input int b);
    if (b < a) return 0;
    return ticks_upto(b) - ticks_upto(a - 1);
  endfunction

  function automatic int next_tick(input int c);
    return c + (TD - 1 - (c % TD));
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] l;
    logic        b;
    l = 16'hACE1;
    for (int i = 0; i < k; i++) begin
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      l = {b, l[15:1]};
    end
    return l;
  endfunction

  task automatic check_model();
    int c, s;
    logic [7:0] st, t, o, g, e;
    c = cyc;
    if (c > rret || c <= rp) begin
      st = 0; t = 8'hA; o = 8'hA; g = 0; e = 0;
    end else if (c > rq) begin
      if (rq <= rtw) begin
        st = 3; t = 9; o = 9; g = 0; e = 1;
      end else begin
        s = ticks_in(re, rq - 1);
        if (s > 99) s = 99;
        st = 3; t = 8'(s / 10); o = 8'(s % 10); g = 0; e = 0;
      end
    end else if (c <= rtw) begin
      st = 1; t = 8'hA; o = 8'hA; g = 0; e = 0;
    end else begin
      s = ticks_in(re, c - 1);
      if (s >= 100) begin
        st = 3; t = 9; o = 9; g = 0; e = 0;
      end else begin
        st = 2; t = 8'(s / 10); o = 8'(s % 10); g = 1; e = 0;
      end
    end
    check("state",  {6'b0, bus.state_o}, st);
    check("tens",   {4'b0, bus.tens},    t);
    check("ones",   {4'b0, bus.ones},    o);
    check("go_led", {7'b0, bus.go_led},  g);
    check("early",  {7'b0, bus.early},   e);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic clear_round();
    rp = BIG; rtw = BIG; re = BIG; rq = BIG; rret = BIG;
  endtask

  task automatic begin_round(input int idle, input int hold);
    int w;
    go_to(cyc + idle);
    rp  = cyc + 2;
    w   = MINW + int'(lfsr_at(rp) % (1 << WB));
    rtw = next_tick(rp + 1) + TD * (w - 1);
    re  = rtw + 1;
    bus.btn = 1'b1;
    repeat (hold) step();
    bus.btn = 1'b0;
  endtask

  task automatic end_by_press(input int q);
    int t100;
    t100 = next_tick(re) + TD * 99;
    if (q < cyc + 4) q = cyc + 4;
    if (q > t100) q = t100;
    go_to(q - 2);
    rq = q;
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    go_to(q + 4);
  endtask

  task automatic return_start();
    rret = cyc + 2;
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    go_to(rret + 3);
    clear_round();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q, idle, hold;
    clear_round();
    bus.btn = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_model();

    // Held button: a single READY entry, then 13 ticks of PLAY
    begin_round(3, 20);
    end_by_press(next_tick(re) + TD * 12 + 1);
    go_to(cyc + 10);
    return_start();

    // False start one tick into READY
    begin_round(1, 1);
    end_by_press(next_tick(rp + 1) + 2);
    return_start();

    // Press on the same cycle as a tick at score 41
    begin_round(2, 1);
    end_by_press(next_tick(re) + TD * 41);
    return_start();

    // Press on the same cycle as the final READY tick
    begin_round(0, 1);
    end_by_press(rtw);
    return_start();

    // No press: count through every carry to the timeout
    begin_round(5, 2);
    go_to(next_tick(re) + TD * 99 + 6);
    return_start();

    // Asynchronous reset in the middle of PLAY
    begin_round(2, 1);
    go_to(re + 10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state",  {6'b0, bus.state_o}, 8'd0);
    check("rst_tens",   {4'b0, bus.tens},    8'hA);
    check("rst_ones",   {4'b0, bus.ones},    8'hA);
    check("rst_go_led", {7'b0, bus.go_led},  8'd0);
    check("rst_early",  {7'b0, bus.early},   8'd0);
    clear_round();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();

    // Wait length after reset proves the LFSR restarted from its seed
    begin_round(4, 1);
    end_by_press(re + 30);
    return_start();

    for (int i = 0; i < 8; i++) begin
      idle = int'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 4));
      begin_round(idle, hold);
      if ($urandom_range(0, 1) == 0) q = rp + 3 + int'($urandom_range(0, 20));
      else                           q = re + int'($urandom_range(0, 420));
      end_by_press(q);
      return_start();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
